serialize_word_to_bit_stream_fsm: RTL and testbench

Parallel-to-serial front end for the bit-serial pattern detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `bit_out`, which drives the detector `a` input. Back-to-back words stream with no bubble. When no word is in flight, the line holds a constant idle level, so downstream FSMs always see a defined bit every cycle.

---
 rtl/serialize_word_to_bit_stream_fsm.sv | 92 +++++++++
 tb/tb_serialize_word_to_bit_stream_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serialize_word_to_bit_stream_fsm.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits one bit per clock.
// When no word is in flight the line holds IDLE_BIT with bit_valid low.
module serialize_word_to_bit_stream_fsm #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             handshake;

    // Outputs decode registered state only; rst merely blocks acceptance during reset cycles.
    always_comb begin
        bit_valid = (state_q == ST_SHIFT);
        last_bit  = bit_valid && (cnt_q == CNT_LAST);
        in_ready  = !rst && (!bit_valid || last_bit);
        bit_out   = IDLE_BIT;
        if (bit_valid) begin
            if (MSB_FIRST) begin
                bit_out = sr_q[WIDTH-1];
            end else begin
                bit_out = sr_q[0];
            end
        end
    end

    assign handshake = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    sr_d    = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    if (MSB_FIRST) begin
                        sr_d = sr_q << 1;
                    end else begin
                        sr_d = sr_q >> 1;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (handshake) begin
                    // Reload on the final bit so consecutive words stream without a gap.
                    sr_d  = in_data;
                    cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serialize_word_to_bit_stream_fsm.sv
// Bench for serialize_word_to_bit_stream_fsm: vector table, directed corner sequences and
// randomized traffic against a queue-of-pending-bits reference model.
module tb_serialize_word_to_bit_stream_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, MSB first, idle low
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ready, m_bit, m_bvalid, m_last;

    serialize_word_to_bit_stream_fsm #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_data(m_data),
        .in_ready(m_ready), .bit_out(m_bit), .bit_valid(m_bvalid), .last_bit(m_last)
    );

    // LSB-first instance with idle high
    logic       l_valid = 1'b0;
    logic [3:0] l_data  = 4'h0;
    logic       l_ready, l_bit, l_bvalid, l_last;

    serialize_word_to_bit_stream_fsm #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(l_valid), .in_data(l_data),
        .in_ready(l_ready), .bit_out(l_bit), .bit_valid(l_bvalid), .last_bit(l_last)
    );

    // Single-bit words
    logic       w_valid = 1'b0;
    logic [0:0] w_data  = 1'b0;
    logic       w_ready, w_bit, w_bvalid, w_last;

    serialize_word_to_bit_stream_fsm #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_data(w_data),
        .in_ready(w_ready), .bit_out(w_bit), .bit_valid(w_bvalid), .last_bit(w_last)
    );

    // Downstream overlapping "1010" Moore detector fed by the main stream
    logic [3:0] det_hist;
    logic       det_pulse;
    always @(posedge clk) det_hist <= rst ? 4'd0 : {det_hist[2:0], m_bit};
    assign det_pulse = (det_hist == 4'b1010);

    int errors = 0;
    int checks = 0;

    logic o_valid, o_bit, o_last, o_ready, o_det;
    logic lo_valid, lo_bit, lo_last, lo_ready;
    logic wo_valid, wo_bit, wo_last, wo_ready;
    logic last_hs;

    // Reference model: bits still owed to the line, in emission order
    bit mq[$];
    bit mlast[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ev, eb, el, er;
    } vec_t;
    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic v, input logic [7:0] d,
                                   input logic ev, input logic eb, input logic el, input logic er);
        vec_t t;
        t.v = v; t.d = d; t.ev = ev; t.eb = eb; t.el = el; t.er = er;
        vecs.push_back(t);
    endfunction

    // One clock cycle: sample all outputs mid-cycle, check the main instance against the model,
    // advance the model by the edge that follows, then return just after that edge.
    task automatic applyStimulus();
        logic ev, eb, el, er;
        @(negedge clk);
        o_valid = m_bvalid; o_bit = m_bit; o_last = m_last; o_ready = m_ready; o_det = det_pulse;
        lo_valid = l_bvalid; lo_bit = l_bit; lo_last = l_last; lo_ready = l_ready;
        wo_valid = w_bvalid; wo_bit = w_bit; wo_last = w_last; wo_ready = w_ready;
        ev = (mq.size() != 0);
        eb = ev ? mq[0] : 1'b0;
        el = ev ? mlast[0] : 1'b0;
        er = !rst && (mq.size() <= 1);
        checkOutput("model.bit_valid", o_valid, ev);
        checkOutput("model.bit_out", o_bit, eb);
        checkOutput("model.last_bit", o_last, el);
        checkOutput("model.in_ready", o_ready, er);
        last_hs = m_valid && er;
        if (rst) begin
            mq.delete();
            mlast.delete();
        end else begin
            if (mq.size() != 0) begin
                void'(mq.pop_front());
                void'(mlast.pop_front());
            end
            if (last_hs) begin
                for (int i = 0; i < 8; i++) begin
                    mq.push_back(m_data[7-i]);
                    mlast.push_back(i == 7);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] a5, cc, h33, h5a, hf0, h81;
        logic [7:0] lseq;
        logic [3:0] wseq;
        int det_count, det_pos;
        bit pending;

        a5 = 8'hA5; cc = 8'hCC; h33 = 8'h33; h5a = 8'h5A; hf0 = 8'hF0; h81 = 8'h81;

        // Single word 0xA5
        addVec(1'b1, a5, 0, 0, 0, 1);
        for (int i = 7; i >= 0; i--) addVec(1'b0, 8'h00, 1, a5[i], i == 0, i == 0);
        addVec(1'b0, 8'h00, 0, 0, 0, 1);
        // Back-to-back 0xCC then 0x33
        addVec(1'b1, cc, 0, 0, 0, 1);
        for (int i = 7; i >= 0; i--) addVec(1'b1, h33, 1, cc[i], i == 0, i == 0);
        for (int i = 7; i >= 0; i--) addVec(1'b0, 8'h00, 1, h33[i], i == 0, i == 0);
        addVec(1'b0, 8'h00, 0, 0, 0, 1);
        // 0xF0 offered from bit 3 of 0x5A; accepted only at its last bit
        addVec(1'b1, h5a, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            addVec(k >= 3, (k >= 3) ? hf0 : 8'h00, 1, h5a[8-k], k == 8, k == 8);
        for (int k = 1; k <= 8; k++) addVec(1'b0, 8'h00, 1, hf0[8-k], k == 8, k == 8);
        addVec(1'b0, 8'h00, 0, 0, 0, 1);

        @(posedge clk);
        #1;
        applyStimulus();
        checkOutput("reset.bit_valid", o_valid, 1'b0);
        checkOutput("reset.bit_out", o_bit, 1'b0);
        checkOutput("reset.last_bit", o_last, 1'b0);
        checkOutput("reset.in_ready", o_ready, 1'b0);
        checkOutput("reset.lsb_bit_out", lo_bit, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            m_valid = vecs[i].v;
            m_data  = vecs[i].d;
            applyStimulus();
            checkOutput($sformatf("vec%0d.bit_valid", i), o_valid, vecs[i].ev);
            checkOutput($sformatf("vec%0d.bit_out", i), o_bit, vecs[i].eb);
            checkOutput($sformatf("vec%0d.last_bit", i), o_last, vecs[i].el);
            checkOutput($sformatf("vec%0d.in_ready", i), o_ready, vecs[i].er);
        end

        // Reset after three bits of 0xFF, then 0x81 must stream cleanly
        m_valid = 1'b1; m_data = 8'hFF;
        applyStimulus();
        m_valid = 1'b0;
        repeat (3) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("midreset.bit_valid", o_valid, 1'b0);
        checkOutput("midreset.in_ready", o_ready, 1'b0);
        rst = 1'b0;
        m_valid = 1'b1; m_data = h81;
        applyStimulus();
        checkOutput("midreset.accept_ready", o_ready, 1'b1);
        m_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus();
            checkOutput($sformatf("midreset.bit%0d", k), o_bit, h81[8-k]);
            checkOutput($sformatf("midreset.valid%0d", k), o_valid, 1'b1);
        end
        applyStimulus();
        checkOutput("midreset.idle_after", o_valid, 1'b0);

        // 0x0A into the "1010" detector: one pulse, the cycle after the 8th bit
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        m_valid = 1'b1; m_data = 8'h0A;
        applyStimulus();
        m_valid = 1'b0;
        det_count = 0; det_pos = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus();
            if (o_det) begin
                det_count++;
                det_pos = k;
            end
        end
        checkCount("detector.pulses", det_count, 1);
        checkCount("detector.cycle", det_pos, 9);

        // LSB-first, idle high: 0x1 then 0x6 back to back
        l_valid = 1'b1; l_data = 4'h1;
        applyStimulus();
        checkOutput("lsb.idle_bit", lo_bit, 1'b1);
        checkOutput("lsb.idle_ready", lo_ready, 1'b1);
        l_data = 4'h6;
        lseq = 8'b0110_0001;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus();
            if (k == 4) l_valid = 1'b0;
            checkOutput($sformatf("lsb.bit%0d", k), lo_bit, lseq[k-1]);
            checkOutput($sformatf("lsb.valid%0d", k), lo_valid, 1'b1);
            checkOutput($sformatf("lsb.last%0d", k), lo_last, (k == 4) || (k == 8));
            checkOutput($sformatf("lsb.ready%0d", k), lo_ready, (k == 4) || (k == 8));
        end
        applyStimulus();
        checkOutput("lsb.idle_after_valid", lo_valid, 1'b0);
        checkOutput("lsb.idle_after_bit", lo_bit, 1'b1);

        // WIDTH=1: one word per cycle, every valid bit is a last bit
        wseq = 4'b1101;
        for (int k = 0; k <= 5; k++) begin
            w_valid = (k < 4);
            w_data  = (k < 4) ? wseq[k] : 1'b0;
            applyStimulus();
            checkOutput($sformatf("w1.valid%0d", k), wo_valid, (k >= 1) && (k <= 4));
            checkOutput($sformatf("w1.bit%0d", k), wo_bit, (k >= 1 && k <= 4) ? wseq[(k >= 1) ? k-1 : 0] : 1'b0);
            checkOutput($sformatf("w1.last%0d", k), wo_last, (k >= 1) && (k <= 4));
            checkOutput($sformatf("w1.ready%0d", k), wo_ready, 1'b1);
        end

        // Randomized source that holds each word until accepted, with sporadic resets
        pending = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!pending && ($urandom_range(3) != 0)) begin
                pending = 1'b1;
                m_data  = 8'($urandom);
            end
            m_valid = pending;
            rst = ($urandom_range(49) == 0);
            applyStimulus();
            if (last_hs) pending = 1'b0;
        end
        rst = 1'b0;
        m_valid = 1'b0;
        repeat (10) applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
